// File: rtl/fetch_redirect_pkg.sv
// fetch_redirect_pkg: shared constants for the fetch PC sequencer.
// Holds the FSM encodings, reset PC default and target alignment helper.
package fetch_redirect_pkg;

    localparam logic [1:0] FR_BOOT  = 2'd0;
    localparam logic [1:0] FR_FETCH = 2'd1;
    localparam logic [1:0] FR_HOLD  = 2'd2;

    localparam logic [31:0] FR_RESET_PC = 32'hBFC0_0000;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] fr_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if: branch-resolution and instruction-memory bundle.
// master = fetch sequencer (drives Imem_req/PC/Fetch_valid/Redirect),
// slave  = ID stage, hazard unit and instruction memory side.
interface fetch_redirect_if;

    logic        Stall;
    logic        Br_valid;
    logic        taken;
    logic [31:0] Br_target;
    logic        Imem_ready;
    logic        Imem_req;
    logic [31:0] PC;
    logic        Fetch_valid;
    logic        Redirect;

    modport master (
        input  Stall, Br_valid, taken, Br_target, Imem_ready,
        output Imem_req, PC, Fetch_valid, Redirect
    );

    modport slave (
        output Stall, Br_valid, taken, Br_target, Imem_ready,
        input  Imem_req, PC, Fetch_valid, Redirect
    );

endinterface

// File: rtl/fetch_redirect_redirect_latch.sv
// redirect_latch: holds a taken redirect until the delay-slot fetch completes.
// Ports: CLK, RESET, set_i (accepted taken), done_i (fetch completion),
//        target_i; valid_o/target_o (pending redirect), accept_o (taken not ignored).
module redirect_latch (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        set_i,
    input  logic        done_i,
    input  logic [31:0] target_i,
    output logic        valid_o,
    output logic [31:0] target_o,
    output logic        accept_o
);

    logic        valid_q, valid_d;
    logic [31:0] tgt_q, tgt_d;

    // A second taken while one is already pending sits in a delay slot
    // and is dropped.
    assign accept_o = set_i && !valid_q;

    always_comb begin
        valid_d = valid_q;
        tgt_d   = tgt_q;
        if (done_i) begin
            // Completion either consumes the pending target or takes the
            // live one directly; nothing remains pending either way.
            valid_d = 1'b0;
        end else if (accept_o) begin
            valid_d = 1'b1;
            tgt_d   = target_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tgt_q   <= tgt_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = tgt_q;

endmodule

// File: rtl/fetch_redirect.sv
// fetch_redirect: PC sequencer applying ID branch resolutions with MIPS delay slots.
// Ports: CLK, RESET (sync, active high), bus (fetch_redirect_if.master);
// with BR_STATS_EN defined also Br_count/Taken_count statistics outputs.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FR_RESET_PC
) (
    input  logic               CLK,
    input  logic               RESET,
    fetch_redirect_if.master   bus
`ifdef BR_STATS_EN
    ,
    output logic [31:0]        Br_count,
    output logic [31:0]        Taken_count
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;

    logic        req;
    logic        done;
    logic        acc;
    logic        take;
    logic        pend_valid;
    logic [31:0] pend_tgt;
    logic [31:0] tgt;
    logic [31:0] next_pc;

    assign tgt  = fr_align(bus.Br_target);
    assign req  = !RESET && (state_q == FR_FETCH);
    assign acc  = !RESET && bus.Br_valid && !bus.Stall;

    // Completion: memory data accepted into IF/ID, either directly in
    // FETCH or from the held copy once the stall drops.
    assign done = !RESET && !bus.Stall &&
                  (((state_q == FR_FETCH) && bus.Imem_ready) ||
                   (state_q == FR_HOLD));

    redirect_latch u_latch (
        .CLK      (CLK),
        .RESET    (RESET),
        .set_i    (acc && bus.taken),
        .done_i   (done),
        .target_i (tgt),
        .valid_o  (pend_valid),
        .target_o (pend_tgt),
        .accept_o (take)
    );

    assign next_pc = pend_valid ? pend_tgt :
                     take       ? tgt      :
                                  pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FR_BOOT:  state_d = FR_FETCH;
            FR_FETCH: if (bus.Imem_ready && bus.Stall) state_d = FR_HOLD;
            FR_HOLD:  if (!bus.Stall) state_d = FR_FETCH;
            default:  state_d = FR_BOOT;
        endcase
    end

    assign pc_d       = done ? next_pc : pc_q;
    assign redirect_d = done && (pend_valid || take);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= FR_BOOT;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.Imem_req    = req;
    assign bus.PC          = pc_q;
    assign bus.Fetch_valid = done;
    assign bus.Redirect    = redirect_q;

`ifdef BR_STATS_EN
    logic [31:0] br_cnt_q, tk_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            if (acc)  br_cnt_q <= br_cnt_q + 32'd1;
            if (take) tk_cnt_q <= tk_cnt_q + 32'd1;
        end
    end

    assign Br_count    = br_cnt_q;
    assign Taken_count = tk_cnt_q;
`endif

endmodule
